// File: rtl/dds_pkg.sv
// Shared DDS definitions: serializer FSM states and default DAC frame constants.
// The LDAC state only exists when DAC_LDAC_EN is defined.
package dds_pkg;

    localparam int         DAC_DATA_LENGTH = 16;
    localparam int         DAC_CMD_LENGTH  = 8;
    localparam logic [7:0] DAC_CMD_VALUE   = 8'h00;
    localparam int         DAC_CLK_DIV     = 2;
    localparam int         DAC_CS_GAP      = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
`ifdef DAC_LDAC_EN
        ,
        LDAC
`endif
    } dac_state_t;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period counter: one-cycle tick every DIV cycles while enabled, cleared when disabled.
module sclk_tick_gen
    import dds_pkg::*;
#(
    parameter int DIV = DAC_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!en_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/dac_serializer.sv
// Shifts {CMD_VALUE, sample} MSB-first to an SPI-style serial DAC (sclk idles low).
// Optional DAC latch strobe and LDAC state are enabled by defining DAC_LDAC_EN.
module dac_serializer
    import dds_pkg::*;
#(
    parameter int                    DATA_LENGTH = DAC_DATA_LENGTH,
    parameter int                    CMD_LENGTH  = DAC_CMD_LENGTH,
    parameter logic [CMD_LENGTH-1:0] CMD_VALUE   = CMD_LENGTH'(DAC_CMD_VALUE),
    parameter int                    CLK_DIV     = DAC_CLK_DIV,
    parameter int                    CS_GAP      = DAC_CS_GAP
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [DATA_LENGTH-1:0] sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   dac_sclk,
    output logic                   dac_mosi,
    output logic                   dac_cs_n,
`ifdef DAC_LDAC_EN
    output logic                   dac_ldac_n,
`endif
    output logic                   busy,
    output logic                   frame_done
);

    localparam int FRAME_LEN = CMD_LENGTH + DATA_LENGTH;
    localparam int BIT_W     = $clog2(FRAME_LEN);
    localparam int GAP_W     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    dac_state_t           state_q;
    logic [FRAME_LEN-1:0] shift_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    logic                 sclk_q;
    logic                 cs_n_q;
    logic                 done_q;
`ifdef DAC_LDAC_EN
    logic                 ldac_n_q;
`endif
    logic                 tick_en;
    logic                 tick;

    // GAP is timed by its own counter, so the divider is held clear there and
    // restarts phase-aligned when LDAC begins.
    always_comb begin
        tick_en = (state_q == SHIFT) || (state_q == HOLD);
`ifdef DAC_LDAC_EN
        if (state_q == LDAC) tick_en = 1'b1;
`endif
    end

    sclk_tick_gen #(
        .DIV(CLK_DIV)
    ) u_tick (
        .clk_i (sys_clk),
        .rst_ni(rst_n),
        .en_i  (tick_en),
        .tick_o(tick)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_n_q  <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        shift_q   <= {CMD_VALUE, sample_in};
                        bit_cnt_q <= '0;
                        sclk_q    <= 1'b0;
                        cs_n_q    <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            // Last bit stays on mosi through the hold time.
                            if (bit_cnt_q == BIT_W'(FRAME_LEN - 1)) begin
                                state_q <= HOLD;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                                shift_q   <= {shift_q[FRAME_LEN-2:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_q    <= 1'b1;
                        shift_q   <= '0;
                        done_q    <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
`ifdef DAC_LDAC_EN
                        ldac_n_q <= 1'b0;
                        state_q  <= LDAC;
`else
                        state_q  <= IDLE;
`endif
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
`ifdef DAC_LDAC_EN
                LDAC: begin
                    if (tick) begin
                        ldac_n_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_ready = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign dac_sclk     = sclk_q;
    assign dac_mosi     = shift_q[FRAME_LEN-1];
    assign dac_cs_n     = cs_n_q;
    assign frame_done   = done_q;
`ifdef DAC_LDAC_EN
    assign dac_ldac_n   = ldac_n_q;
`endif

endmodule

// File: tb/tb_dac_serializer.sv
// Randomized bench for dac_serializer: outputs checked every cycle against a
// timing-formula model, plus an SPI receiver that decodes each frame on sclk rises.
module tb_dac_serializer;

    localparam int DL   = 16;
    localparam int CL   = 8;
    localparam int D    = 2;
    localparam int G    = 2;
    localparam int N    = DL + CL;
    localparam logic [CL-1:0] CMD = 8'h00;
    localparam int T_SH = 2 * D * N;
    localparam int T_CS = T_SH + D;
`ifdef DAC_LDAC_EN
    localparam int P    = T_CS + G + D + 1;
`else
    localparam int P    = T_CS + G + 1;
`endif
    // {ready, busy, cs_n, sclk, mosi, done, ldac_n}
    localparam logic [6:0] IDLE_V = 7'b1010001;

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic [DL-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic          dac_sclk;
    logic          dac_mosi;
    logic          dac_cs_n;
    logic          dac_ldac_n;
    logic          busy;
    logic          frame_done;
    logic [6:0]    obs;

    always #5 sys_clk = ~sys_clk;

    dac_serializer #(
        .DATA_LENGTH(DL),
        .CMD_LENGTH (CL),
        .CMD_VALUE  (CMD),
        .CLK_DIV    (D),
        .CS_GAP     (G)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .dac_sclk    (dac_sclk),
        .dac_mosi    (dac_mosi),
        .dac_cs_n    (dac_cs_n),
`ifdef DAC_LDAC_EN
        .dac_ldac_n  (dac_ldac_n),
`endif
        .busy        (busy),
        .frame_done  (frame_done)
    );

`ifndef DAC_LDAC_EN
    assign dac_ldac_n = 1'b1;
`endif
    assign obs = {sample_ready, busy, dac_cs_n, dac_sclk, dac_mosi, frame_done, dac_ldac_n};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state
    int           e    = 0;
    int           hs   = 0;
    bit           act  = 0;
    bit           rdy_m = 1;
    bit           acc  = 0;
    logic [N-1:0] f_m  = '0;
    // Serial receiver state
    logic [N-1:0] rx   = '0;
    int           rxn  = 0;
    logic         p_sclk = 1'b0;
    logic         p_cs   = 1'b1;

    // Expected outputs k cycles after the handshake edge, from the frame timing rules.
    function automatic logic [6:0] model_out(input int k, input logic [N-1:0] f, input bit a);
        int b;
        if (!a) return IDLE_V;
        if (k <= T_SH) begin
            b = (k - 1) / (2 * D);
            return {1'b0, 1'b1, 1'b0, (((k - 1) % (2 * D)) >= D), f[N-1-b], 1'b0, 1'b1};
        end
        if (k <= T_CS)     return {1'b0, 1'b1, 1'b0, 1'b0, f[0], 1'b0, 1'b1};
        if (k <= T_CS + G) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (k == T_CS + 1), 1'b1};
`ifdef DAC_LDAC_EN
        if (k <= T_CS + G + D) return 7'b0110000;
`endif
        return IDLE_V;
    endfunction

    task automatic step(input bit v, input logic [DL-1:0] d);
        int k;
        logic [6:0] ex;
        sample_valid = v;
        sample_in    = d;
        @(posedge sys_clk);
        e++;
        acc = 0;
        if (rdy_m && v) begin
            hs  = e;
            f_m = {CMD, d};
            act = 1;
            acc = 1;
        end
        @(negedge sys_clk);
        k  = e - hs + 1;
        ex = model_out(k, f_m, act);
        if (act && k >= P) act = 0;
        rdy_m = ex[6];
        chk($sformatf("out k=%0d", act ? k : 0), {25'd0, obs}, {25'd0, ex});
        if (!p_sclk && dac_sclk) begin
            rx = {rx[N-2:0], dac_mosi};
            rxn++;
        end
        if (p_cs && !dac_cs_n) rxn = 0;
        if (!p_cs && dac_cs_n) begin
            chk("frame", {8'd0, rx}, {8'd0, f_m});
            chk("nbits", rxn, N);
        end
        p_sclk = dac_sclk;
        p_cs   = dac_cs_n;
    endtask

    // Asserted mid-cycle so the outputs must drop without a clock edge.
    task automatic do_reset(input int hold);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {25'd0, obs}, {25'd0, IDLE_V});
        act = 0; rdy_m = 1; rxn = 0; p_sclk = 1'b0; p_cs = 1'b1;
        sample_valid = 1'b0;
        repeat (hold) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk("rst_hold", {25'd0, obs}, {25'd0, IDLE_V});
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        @(negedge sys_clk);
        do_reset(3);
        repeat (10) step(0, '0);

        // Single frame with a rejected mid-frame valid
        step(1, 16'hA5C3);
        repeat (18) step(0, 16'h1234);
        step(1, 16'hFFFF);
        repeat (90) step(0, '0);

        // Back-to-back with valid held high
        step(1, 16'h0001);
        for (int i = 0; i < 2 * P; i++) begin
            step(1, 16'h8000);
            if (acc) break;
        end
        repeat (P + 10) step(0, '0);

        // Reset at k=40, then a clean frame
        step(1, 16'h5A3C);
        repeat (38) step(0, '0);
        do_reset(2);
        step(1, 16'hC0DE);
        repeat (P + 10) step(0, '0);

        // Random traffic, samples changing every cycle, occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset(1);
            step($urandom_range(0, 7) != 0, DL'($urandom));
        end
        repeat (P + 5) step(0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_serializer.md
# dac_serializer

Downstream stage of the DDS core: takes each parallel waveform sample and shifts it out MSB-first to an external serial DAC. The DAC interface is SPI-style: `dac_sclk` idles low and the DAC samples data on the rising edge. The block runs entirely in the `sys_clk` domain. It uses a valid/ready handshake on the sample side and reports one pulse per finished frame.

## Interface
- `DATA_LENGTH`, 16: sample width. Matches the DDS `OUT_LENGTH`.
- `CMD_LENGTH`, 8: number of command/prefix bits sent ahead of the sample. Range 1..16.
- `CMD_VALUE`, 8'h00: prefix bit pattern, `CMD_LENGTH` bits wide.
- `CLK_DIV`, 2: `sys_clk` cycles per `dac_sclk` half-period. Must be ≥1.
- `CS_GAP`, 2: minimum `sys_clk` cycles `dac_cs_n` stays high between frames. Must be ≥1.
- `sys_clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active low.
- `sample_in` in `DATA_LENGTH`: sample to transmit.
- `sample_valid` in 1: `sample_in` is valid.
- `sample_ready` out 1: block can accept a sample.
- `dac_sclk` out 1: serial clock.
- `dac_mosi` out 1: serial data.
- `dac_cs_n` out 1: frame select, active low.
- `dac_ldac_n` out 1: DAC latch strobe. Present only when `DAC_LDAC_EN` is defined.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse when `dac_cs_n` rises.

## Operation
- Frame is the concatenation {`CMD_VALUE`, sample}, N = `CMD_LENGTH`+`DATA_LENGTH` bits. It is shifted MSB first.
- Handshake: a sample is accepted on a rising edge where `sample_valid`&&`sample_ready`. `sample_in` is captured into the frame register on that same edge.
- `sample_ready` = (state==IDLE), decoded combinationally from the state register.
- `sample_valid` while not ready is ignored and nothing is captured. Changes on `sample_in` during a frame do not affect the frame in flight.
- FSM states and transitions:
  - IDLE → SHIFT on handshake.
  - SHIFT → HOLD after the last `dac_sclk` fall.
  - HOLD → GAP after `CLK_DIV` cycles.
  - GAP → IDLE after `CS_GAP` cycles, or GAP → LDAC when `DAC_LDAC_EN` is defined.
  - LDAC → IDLE after `CLK_DIV` cycles.
- Data changes only while `dac_sclk` is low. `dac_mosi` is driven 0 whenever `dac_cs_n`=1.
- Reset values: `dac_cs_n`=1, `dac_sclk`=0, `dac_mosi`=0, `dac_ldac_n`=1, `busy`=0, `frame_done`=0, state IDLE, so `sample_ready`=1.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously) and the partial frame is discarded. No `frame_done` pulse is generated.
- Back-to-back frames: if `sample_valid` is held high, the next frame starts on the first IDLE cycle, so IDLE lasts exactly one cycle.

## Timing
- Let k be the cycle count after the handshake edge (k=0 is the handshake edge) and D = `CLK_DIV`.
- k=1: `dac_cs_n`=0, `dac_sclk`=0, `dac_mosi`=frame bit N-1, `busy`=1.
- For bit b = 0..N-1:
  - `dac_mosi` is updated at k = 1+2D·b.
  - `dac_sclk` rises at k = 1+D(2b+1).
  - `dac_sclk` falls at k = 1+D(2b+2).
- The last fall is at k = 1+2DN. After it, `dac_cs_n` stays low for a further D cycles of hold time.
- `dac_cs_n` rises, and `frame_done`=1 for exactly one cycle, at k = 1+D(2N+1).
- GAP holds `dac_cs_n` high for `CS_GAP` cycles.
- Without `DAC_LDAC_EN`: `sample_ready`=1 at k = 1+D(2N+1)+`CS_GAP`.
- With `DAC_LDAC_EN`: `sample_ready`=1 at k = 1+D(2N+1)+`CS_GAP`+D.
- Defaults (N=24, D=2, `CS_GAP`=2, no LDAC):
  - `dac_cs_n` rises at k=99.
  - `sample_ready` returns at k=101.
  - Frame period is 101 cycles.

## Configuration
- `DAC_LDAC_EN` defined:
  - The `dac_ldac_n` port and the LDAC state exist.
  - `dac_ldac_n` is 0 for exactly D cycles, starting the cycle after GAP ends. It is 1 otherwise.
- `DAC_LDAC_EN` undefined:
  - No LDAC port and no LDAC state.
  - GAP → IDLE directly.

## Structure
- Shared package `dds_pkg` holds:
  - the `dac_state_t` enum (IDLE, SHIFT, HOLD, GAP, LDAC);
  - the default frame constants.
- Sub-module `sclk_tick_gen` is a half-period counter. It emits a one-cycle tick every D cycles while enabled and clears when disabled. The FSM advances bits and toggles `dac_sclk` on its ticks.

## Test plan
- **Reset:** hold `rst_n`=0 → `dac_cs_n`=1, `dac_sclk`=0, `dac_mosi`=0, `sample_ready`=1. After release, idle for 10 cycles → no edges on `dac_sclk`.
- **Single frame:** `sample_in`=16'hA5C3 (defaults) → 24 rising `dac_sclk` edges sample 24'h00A5C3 → `dac_cs_n` low for k=1..98 → `frame_done` at k=99 → `sample_ready` at k=101.
- **Busy:** `sample_valid` pulsed with 16'hFFFF at k=20 → ignored, and the frame in flight is unchanged.
- **Back-to-back:** valid held high with 16'h0001 then 16'h8000 → second `dac_cs_n` fall at k=102 → both frames decode correctly.
- **Mid-frame reset:** `rst_n` low at k=40 → `dac_cs_n`=1 and `dac_sclk`=0 in the same cycle, no `frame_done` → a new frame after release is correct.
- **`DAC_LDAC_EN`:** default frame → `dac_ldac_n` low at k=101..102 → `sample_ready` at k=103.
